// File: rtl/ricpu_dbg_pkg.sv
// ricpu_dbg_pkg
// Shared definitions for the RICPU run/reset controller:
//   - run_state_t : controller state encoding (RESET, HALT, RUN, STEP)
//   - FLAG_ZF / FLAG_OF : bit positions inside last_flags
//   - clog2       : constant-evaluable ceiling log2 used for index widths
package ricpu_dbg_pkg;

    typedef enum logic [1:0] {
        RESET,
        HALT,
        RUN,
        STEP
    } run_state_t;

    localparam int unsigned FLAG_ZF = 0;
    localparam int unsigned FLAG_OF = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ricpu_trace_buf.sv
// ricpu_trace_buf
// Circular trace buffer of {pc, alu} pairs. One entry is written per wr_en
// cycle at wr_ptr; the pointer wraps modulo DEPTH and overwrites the oldest
// entry. Storage is not reset, only the pointer. Reads are combinational.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (pointer only)
//   wr_en          : write strobe (CPU clock enable)
//   wr_pc, wr_alu  : entry data
//   rd_idx         : read slot
//   rd_pc, rd_alu  : entry at rd_idx
//   wr_ptr         : next slot to be written
module ricpu_trace_buf
    import ricpu_dbg_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [PC_W-1:0]           wr_pc,
    input  logic [DATA_W-1:0]         wr_alu,
    input  logic [clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_W-1:0]           rd_pc,
    output logic [DATA_W-1:0]         rd_alu,
    output logic [clog2(DEPTH)-1:0]   wr_ptr
);

    logic [PC_W-1:0]   pc_mem  [DEPTH];
    logic [DATA_W-1:0] alu_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]  <= wr_pc;
            alu_mem[wr_ptr] <= wr_alu;
        end
    end

    // DEPTH is a power of two, so natural overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign rd_pc  = pc_mem[rd_idx];
    assign rd_alu = alu_mem[rd_idx];

endmodule

// File: rtl/ricpu_run_ctrl.sv
// ricpu_run_ctrl
// Run/reset controller and result monitor between board clock/reset and the
// RICPU core. Stretches the CPU reset, gates CPU progress via cpu_ce (free
// run, single step, PC breakpoint) and captures results of enabled cycles.
// Optional feature macro: RICPU_TRACE_EN (adds the {pc, alu} trace buffer;
// otherwise the trace outputs read as zero).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mode_run, step_req       : free-run level, single-step pulse
//   bp_en, bp_addr           : PC breakpoint enable and address
//   clr_sticky               : clears bp_hit and of_sticky
//   cpu_pc, alu_f, fr_zf,
//   fr_of, mem_r_data        : observed CPU signals
//   cpu_rst, cpu_ce, halted  : combinational state decode
//   bp_hit, of_sticky        : sticky status
//   cycle_cnt                : saturating count of enabled cycles
//   last_alu_f, last_mem,
//   last_flags               : values captured on the last enabled cycle
//   trace_rd_idx, trace_rd_pc,
//   trace_rd_alu, trace_wr_ptr : trace buffer access
module ricpu_run_ctrl
    import ricpu_dbg_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned CYC_W       = 32,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode_run,
    input  logic                           step_req,
    input  logic                           bp_en,
    input  logic [PC_W-1:0]                bp_addr,
    input  logic                           clr_sticky,
    input  logic [PC_W-1:0]                cpu_pc,
    input  logic [DATA_W-1:0]              alu_f,
    input  logic                           fr_zf,
    input  logic                           fr_of,
    input  logic [DATA_W-1:0]              mem_r_data,
    output logic                           cpu_rst,
    output logic                           cpu_ce,
    output logic                           halted,
    output logic                           bp_hit,
    output logic                           of_sticky,
    output logic [CYC_W-1:0]               cycle_cnt,
    output logic [DATA_W-1:0]              last_alu_f,
    output logic [DATA_W-1:0]              last_mem,
    output logic [1:0]                     last_flags,
    input  logic [clog2(TRACE_DEPTH)-1:0]  trace_rd_idx,
    output logic [PC_W-1:0]                trace_rd_pc,
    output logic [DATA_W-1:0]              trace_rd_alu,
    output logic [clog2(TRACE_DEPTH)-1:0]  trace_wr_ptr
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? clog2(RST_CYCLES) : 1;

    run_state_t      state, state_nxt;
    logic [RC_W-1:0] rst_cnt, rst_cnt_nxt;
    logic            skip, skip_nxt;
    logic            ce_raw;
    logic            bp_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET;
            rst_cnt <= RC_W'(RST_CYCLES - 1);
            skip    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= rst_cnt_nxt;
            skip    <= skip_nxt;
        end
    end

    // skip suppresses the breakpoint for the first RUN cycle after a resume,
    // so restarting at the breakpoint PC executes that instruction.
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        skip_nxt    = skip;
        ce_raw      = 1'b0;
        bp_fire     = 1'b0;
        case (state)
            RESET: begin
                if (rst_cnt == '0) begin
                    state_nxt = mode_run ? RUN : HALT;
                end else begin
                    rst_cnt_nxt = rst_cnt - 1'b1;
                end
            end
            HALT: begin
                if (mode_run) begin
                    state_nxt = RUN;
                    skip_nxt  = 1'b1;
                end else if (step_req) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                ce_raw    = 1'b1;
                state_nxt = HALT;
            end
            RUN: begin
                skip_nxt = 1'b0;
                bp_fire  = bp_en && (cpu_pc == bp_addr) && !skip;
                ce_raw   = !bp_fire;
                if (bp_fire || !mode_run) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = RESET;
        endcase
    end

    // rst overrides the state decode immediately so an aborted RUN/STEP
    // cycle never enables the CPU.
    assign cpu_ce  = ce_raw & ~rst;
    assign cpu_rst = rst | (state == RESET);
    assign halted  = ~rst & (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt  <= '0;
            last_alu_f <= '0;
            last_mem   <= '0;
            last_flags <= '0;
            bp_hit     <= 1'b0;
            of_sticky  <= 1'b0;
        end else begin
            if (cpu_ce) begin
                last_alu_f          <= alu_f;
                last_mem            <= mem_r_data;
                last_flags[FLAG_OF] <= fr_of;
                last_flags[FLAG_ZF] <= fr_zf;
                if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
            end
            // Set has priority over a same-cycle clear.
            bp_hit    <= bp_fire | (bp_hit & ~clr_sticky);
            of_sticky <= (cpu_ce & fr_of) | (of_sticky & ~clr_sticky);
        end
    end

`ifdef RICPU_TRACE_EN
    ricpu_trace_buf #(
        .DEPTH  (TRACE_DEPTH),
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_trace (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (cpu_ce),
        .wr_pc  (cpu_pc),
        .wr_alu (alu_f),
        .rd_idx (trace_rd_idx),
        .rd_pc  (trace_rd_pc),
        .rd_alu (trace_rd_alu),
        .wr_ptr (trace_wr_ptr)
    );
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_rd_idx;
    assign trace_rd_pc      = '0;
    assign trace_rd_alu     = '0;
    assign trace_wr_ptr     = '0;
`endif

endmodule

// File: tb/tb_ricpu_run_ctrl.sv
`timescale 1ns/1ps
module tb_ricpu_run_ctrl;

    localparam int DW   = 32;
    localparam int PW   = 32;
    localparam int RSTC = 2;
    localparam int CW   = 4;
    localparam int TD   = 8;
    localparam int TIW  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, mode_run, step_req, bp_en, clr_sticky, fr_zf, fr_of;
    logic [PW-1:0]  bp_addr, cpu_pc;
    logic [DW-1:0]  alu_f, mem_r_data;
    logic           cpu_rst, cpu_ce, halted, bp_hit, of_sticky;
    logic [CW-1:0]  cycle_cnt;
    logic [DW-1:0]  last_alu_f, last_mem;
    logic [1:0]     last_flags;
    logic [TIW-1:0] trace_rd_idx, trace_wr_ptr;
    logic [PW-1:0]  trace_rd_pc;
    logic [DW-1:0]  trace_rd_alu;

    ricpu_run_ctrl #(
        .DATA_W(DW), .PC_W(PW), .RST_CYCLES(RSTC), .CYC_W(CW), .TRACE_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst), .mode_run(mode_run), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .clr_sticky(clr_sticky),
        .cpu_pc(cpu_pc), .alu_f(alu_f), .fr_zf(fr_zf), .fr_of(fr_of),
        .mem_r_data(mem_r_data), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce),
        .halted(halted), .bp_hit(bp_hit), .of_sticky(of_sticky),
        .cycle_cnt(cycle_cnt), .last_alu_f(last_alu_f), .last_mem(last_mem),
        .last_flags(last_flags), .trace_rd_idx(trace_rd_idx),
        .trace_rd_pc(trace_rd_pc), .trace_rd_alu(trace_rd_alu),
        .trace_wr_ptr(trace_wr_ptr)
    );

    typedef struct {
        logic           rst, mode_run, step_req, bp_en, clr, zf, of;
        logic [31:0]    pc, bp_addr, alu, mem;
        logic [TIW-1:0] idx;
    } in_t;

    typedef struct {
        bit step;
        bit e_rst, e_ce, e_halt;
        int e_cnt;
    } vec_t;

    in_t  cur;
    vec_t tbl[15];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: the controller viewed as "reset cycles remaining",
    // "running", "one step pending" plus the bookkeeping it exposes.
    int          m_rst_left = 0;
    bit          m_run = 0, m_step = 0, m_skip = 0, m_valid = 0;
    int          m_cnt = 0;
    logic [31:0] m_alu = '0, m_mem = '0;
    logic [1:0]  m_flags = '0;
    bit          m_bp = 0, m_of = 0;
    logic [31:0] m_tr_pc [TD];
    logic [31:0] m_tr_alu[TD];
    bit          m_tr_v  [TD];
    int          m_wp = 0;

    function automatic bit m_bpf(input in_t v);
        return !v.rst && m_rst_left == 0 && !m_step && m_run && v.bp_en
               && v.pc == v.bp_addr && !m_skip;
    endfunction

    function automatic bit m_ce(input in_t v);
        if (v.rst || m_rst_left > 0) return 1'b0;
        if (m_step) return 1'b1;
        if (m_run) return !m_bpf(v);
        return 1'b0;
    endfunction

    function automatic bit m_halt(input in_t v);
        return !v.rst && m_rst_left == 0 && !m_run && !m_step;
    endfunction

    task automatic model_step(input in_t v);
        bit ce, bpf;
        ce  = m_ce(v);
        bpf = m_bpf(v);
        if (v.rst) begin
            m_rst_left = RSTC; m_run = 0; m_step = 0; m_skip = 0;
            m_cnt = 0; m_alu = '0; m_mem = '0; m_flags = '0;
            m_bp = 0; m_of = 0; m_wp = 0; m_valid = 1;
            return;
        end
        if (ce) begin
            m_alu = v.alu; m_mem = v.mem; m_flags = {v.of, v.zf};
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_tr_pc[m_wp] = v.pc; m_tr_alu[m_wp] = v.alu; m_tr_v[m_wp] = 1;
            m_wp = (m_wp + 1) % TD;
        end
        m_bp = bpf || (m_bp && !v.clr);
        m_of = (ce && v.of) || (m_of && !v.clr);
        if (m_rst_left > 0) begin
            m_rst_left = m_rst_left - 1;
            if (m_rst_left == 0) begin m_run = v.mode_run; m_skip = 0; end
        end else if (m_step) begin
            m_step = 0;
        end else if (m_run) begin
            m_skip = 0;
            if (bpf || !v.mode_run) m_run = 0;
        end else if (v.mode_run) begin
            m_run = 1; m_skip = 1;
        end else if (v.step_req) begin
            m_step = 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        rst = cur.rst; mode_run = cur.mode_run; step_req = cur.step_req;
        bp_en = cur.bp_en; bp_addr = cur.bp_addr; clr_sticky = cur.clr;
        cpu_pc = cur.pc; alu_f = cur.alu; mem_r_data = cur.mem;
        fr_zf = cur.zf; fr_of = cur.of; trace_rd_idx = cur.idx;
    endtask

    // Drive this cycle's inputs, then check against the model mid-cycle.
    task automatic half();
        drive();
        @(negedge clk);
        chk("cpu_rst", cpu_rst, (cur.rst || m_rst_left > 0));
        chk("cpu_ce", cpu_ce, m_ce(cur));
        chk("halted", halted, m_halt(cur));
        if (m_valid) begin
            chk("cycle_cnt", cycle_cnt, m_cnt);
            chk("last_alu_f", last_alu_f, m_alu);
            chk("last_mem", last_mem, m_mem);
            chk("last_flags", last_flags, m_flags);
            chk("bp_hit", bp_hit, m_bp);
            chk("of_sticky", of_sticky, m_of);
`ifdef RICPU_TRACE_EN
            chk("trace_wr_ptr", trace_wr_ptr, m_wp);
            if (m_tr_v[cur.idx]) begin
                chk("trace_rd_pc", trace_rd_pc, m_tr_pc[cur.idx]);
                chk("trace_rd_alu", trace_rd_alu, m_tr_alu[cur.idx]);
            end
`else
            chk("trace_tied", {trace_rd_pc, trace_rd_alu}, 64'd0);
            chk("trace_ptr_tied", trace_wr_ptr, 0);
`endif
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
        model_step(cur);
    endtask

    task automatic cycle();
        half();
        clk_edge();
    endtask

    initial begin
        cur = '{default: 0};
        cur.rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        model_step(cur);
        cur.rst = 1'b0;

        // Reset stretch then three steps 4 cycles apart; extra pulse in STEP.
        //         step rst ce halt cnt
        tbl[0]  = '{0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 1, 1};
        tbl[7]  = '{1, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 2};
        tbl[10] = '{0, 0, 0, 1, 2};
        tbl[11] = '{1, 0, 0, 1, 2};
        tbl[12] = '{0, 0, 1, 0, 2};
        tbl[13] = '{0, 0, 0, 1, 3};
        tbl[14] = '{0, 0, 0, 1, 3};
        for (int i = 0; i < 15; i++) begin
            cur.step_req = tbl[i].step;
            half();
            chk($sformatf("tbl%0d_cpu_rst", i), cpu_rst, tbl[i].e_rst);
            chk($sformatf("tbl%0d_cpu_ce", i), cpu_ce, tbl[i].e_ce);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
            chk($sformatf("tbl%0d_cycle_cnt", i), cycle_cnt, tbl[i].e_cnt);
            clk_edge();
        end
        cur.step_req = 1'b0;

        // Breakpoint at 0x0C, then resume past it.
        cur.bp_en = 1'b1; cur.bp_addr = 32'h0C; cur.mode_run = 1'b1; cur.pc = '0;
        cycle();
        for (int p = 0; p < 12; p += 4) begin
            cur.pc = 32'(p);
            half(); chk("bp_run_ce", cpu_ce, 1); clk_edge();
        end
        cur.pc = 32'h0C; cur.mode_run = 1'b0;
        half(); chk("bp_fire_ce", cpu_ce, 0); clk_edge();
        half(); chk("bp_halted", halted, 1); chk("bp_hit_set", bp_hit, 1); clk_edge();
        cur.mode_run = 1'b1;
        cycle();
        half(); chk("resume_ce_at_bp", cpu_ce, 1); clk_edge();
        cur.pc = 32'h10;
        half(); chk("resume_ce_next", cpu_ce, 1); clk_edge();
        cur.mode_run = 1'b0; cur.bp_en = 1'b0;
        half(); chk("stop_last_ce", cpu_ce, 1); clk_edge();

        // Capture and sticky overflow.
        cur.clr = 1'b1; cycle(); cur.clr = 1'b0;
        half(); chk("clr_bp_hit", bp_hit, 0); clk_edge();
        cur.step_req = 1'b1; cycle(); cur.step_req = 1'b0;
        cur.alu = 32'h8000_0000; cur.of = 1'b1; cur.zf = 1'b0; cur.mem = 32'hCAFE_F00D;
        half(); chk("cap_step_ce", cpu_ce, 1); clk_edge();
        cur.alu = '0; cur.of = 1'b0; cur.mem = '0;
        half();
        chk("cap_alu", last_alu_f, 32'h8000_0000);
        chk("cap_flags", last_flags, 2'b10);
        chk("cap_mem", last_mem, 32'hCAFE_F00D);
        chk("cap_of_sticky", of_sticky, 1);
        clk_edge();
        cur.step_req = 1'b1; cycle(); cur.step_req = 1'b0;
        cur.of = 1'b1; cur.clr = 1'b1; cur.alu = 32'd5;
        cycle();
        cur.of = 1'b0; cur.clr = 1'b0;
        half(); chk("set_beats_clr", of_sticky, 1); clk_edge();
        cur.clr = 1'b1; cycle(); cur.clr = 1'b0;
        half(); chk("of_cleared", of_sticky, 0); clk_edge();

        // Saturation, then reset mid-run.
        cur.mode_run = 1'b1;
        repeat (20) cycle();
        half(); chk("cnt_saturated", cycle_cnt, CMAX); clk_edge();
        cur.rst = 1'b1;
        half(); chk("rst_held_ce", cpu_ce, 0); chk("rst_held_cpu_rst", cpu_rst, 1);
        chk("rst_held_halted", halted, 0); clk_edge();
        half(); chk("rst_cnt_cleared", cycle_cnt, 0); chk("rst_state_ce", cpu_ce, 0);
        chk("rst_state_cpu_rst", cpu_rst, 1); clk_edge();
        cur.rst = 1'b0;

        // Reset straight into RUN, 10 enabled cycles with alu_f=k.
        cycle();
        cycle();
        for (int k = 1; k <= 10; k++) begin
            cur.alu = 32'(k); cur.pc = 32'(k * 4);
            if (k == 10) cur.mode_run = 1'b0;
            half(); chk($sformatf("trace_run%0d_ce", k), cpu_ce, 1); clk_edge();
        end
`ifdef RICPU_TRACE_EN
        cur.idx = 3'd0; half();
        chk("trace_ptr_wrap", trace_wr_ptr, 2); chk("trace_slot0", trace_rd_alu, 9); clk_edge();
        cur.idx = 3'd1; half(); chk("trace_slot1", trace_rd_alu, 10); clk_edge();
        cur.idx = 3'd2; half(); chk("trace_slot2", trace_rd_alu, 3);
        chk("trace_slot2_pc", trace_rd_pc, 12); clk_edge();
`else
        cur.idx = 3'd2; half();
        chk("trace_off_ptr", trace_wr_ptr, 0); chk("trace_off_alu", trace_rd_alu, 0); clk_edge();
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cur.rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) cur.mode_run = ~cur.mode_run;
            cur.step_req = ($urandom_range(0, 3) == 0);
            cur.bp_en    = 1'($urandom_range(0, 1));
            cur.bp_addr  = 32'($urandom_range(0, 3) * 4);
            cur.pc       = 32'($urandom_range(0, 3) * 4);
            cur.alu      = $urandom;
            cur.mem      = $urandom;
            cur.zf       = 1'($urandom_range(0, 1));
            cur.of       = 1'($urandom_range(0, 1));
            cur.clr      = ($urandom_range(0, 5) == 0);
            cur.idx      = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
